// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide unit sequencer.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MFHI     = 4'd5,
    MFLO     = 4'd6,
    MTHI     = 4'd7,
    MTLO     = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath; returns the {HI, LO} an op would leave behind.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] den_u;
  logic [31:0] den_s;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes, which also makes 0x80000000 / -1
  // fall out naturally as quotient 0x80000000, remainder 0.
  assign b_zero = (b == 32'd0);
  assign abs_a  = a[31] ? -a : a;
  assign abs_b  = b[31] ? -b : b;
  assign den_u  = b_zero ? 32'd1 : b;
  assign den_s  = b_zero ? 32'd1 : abs_b;
  assign q_mag  = abs_a / den_s;
  assign r_mag  = abs_a % den_s;
  assign q_s    = (a[31] ^ b[31]) ? -q_mag : q_mag;
  assign r_s    = a[31] ? -r_mag : r_mag;

  always_comb begin
    res_hi = hi_cur;
    res_lo = lo_cur;
    case (op)
      MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      DIV: begin
        if (!b_zero) begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      DIVU: begin
        if (!b_zero) begin
          res_hi = a % den_u;
          res_lo = a / den_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage MDU sequencer: owns HI/LO, models fixed op latency, drives busy.
//   state   | meaning
//   ST_IDLE | ready; accepts mult/div (to RUN) and mthi/mtlo (direct write)
//   ST_RUN  | op in flight; cnt counts down, result commits when cnt==1
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_op,
  input  logic        E_MDU_start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        req,
  output logic        E_MDU_busy,
  output logic [31:0] E_MDU_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      temp_hi;
  logic [31:0]      temp_lo;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             accept;

  mdu_arith u_arith (
    .op     (E_MDU_op),
    .a      (E_A),
    .b      (E_B),
    .hi_cur (HI),
    .lo_cur (LO),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // A flushed instruction must leave HI/LO untouched.
  assign accept    = E_MDU_start & ~req;
  assign E_MDU_out = (E_MDU_op == MFHI) ? HI : LO;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      temp_hi    <= '0;
      temp_lo    <= '0;
      HI         <= '0;
      LO         <= '0;
      E_MDU_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (E_MDU_op)
              MULT, MULTU: begin
                temp_hi    <= res_hi;
                temp_lo    <= res_lo;
                cnt        <= MULT_LOAD;
                state      <= ST_RUN;
                E_MDU_busy <= 1'b1;
              end
              DIV, DIVU: begin
                temp_hi    <= res_hi;
                temp_lo    <= res_lo;
                cnt        <= DIV_LOAD;
                state      <= ST_RUN;
                E_MDU_busy <= 1'b1;
              end
              MTHI: HI <= E_A;
              MTLO: LO <= E_A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            HI         <= temp_hi;
            LO         <= temp_lo;
            state      <= ST_IDLE;
            E_MDU_busy <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          E_MDU_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDU_op;
  logic        E_MDU_start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        req;
  logic        E_MDU_busy;
  logic [31:0] E_MDU_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;
  int illegal_starts = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .E_MDU_op   (E_MDU_op),
    .E_MDU_start(E_MDU_start),
    .E_A        (E_A),
    .E_B        (E_B),
    .req        (req),
    .E_MDU_busy (E_MDU_busy),
    .E_MDU_out  (E_MDU_out),
    .HI         (HI),
    .LO         (LO)
  );

  // Protocol monitor: a start while busy is illegal and must be ignored.
  always @(negedge clk)
    if (reset && E_MDU_start && E_MDU_busy) illegal_starts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cycles_of(input logic [3:0] op);
    if (op == OP_MULT || op == OP_MULTU) return 5;
    if (op == OP_DIV || op == OP_DIVU) return 10;
    return 0;
  endfunction

  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  begin p = longint'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      OP_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      OP_MTHI:  m_hi = a;
      OP_MTLO:  m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic check_hilo(input string tag);
    checks++;
    if (HI !== m_hi) begin errors++; $display("FAIL %s HI: got %h expected %h", tag, HI, m_hi); end
    checks++;
    if (LO !== m_lo) begin errors++; $display("FAIL %s LO: got %h expected %h", tag, LO, m_lo); end
  endtask

  task automatic check_out(input string tag);
    E_MDU_op = OP_MFHI; #1;
    checks++;
    if (E_MDU_out !== m_hi) begin errors++; $display("FAIL %s mfhi: got %h expected %h", tag, E_MDU_out, m_hi); end
    E_MDU_op = OP_MFLO; #1;
    checks++;
    if (E_MDU_out !== m_lo) begin errors++; $display("FAIL %s mflo: got %h expected %h", tag, E_MDU_out, m_lo); end
    E_MDU_op = OP_MULT; #1;
    checks++;
    if (E_MDU_out !== m_lo) begin errors++; $display("FAIL %s out_other: got %h expected %h", tag, E_MDU_out, m_lo); end
    E_MDU_op = OP_NONE;
  endtask

  // Issue one op for a single cycle, measure the busy window, compare HI/LO.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq, input string tag);
    int n;
    int exp_n;
    E_MDU_op = op; E_A = a; E_B = b; req = rq; E_MDU_start = 1'b1;
    tick();
    E_MDU_start = 1'b0; req = 1'b0;
    exp_n = rq ? 0 : cycles_of(op);
    n = 0;
    while (E_MDU_busy && n < 40) begin n++; tick(); end
    checks++;
    if (n !== exp_n) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, exp_n); end
    if (!rq) model_op(op, a, b);
    check_hilo(tag);
  endtask

  task automatic test_reset();
    reset = 1'b0; E_MDU_op = OP_NONE; E_MDU_start = 1'b0; E_A = '0; E_B = '0; req = 1'b0;
    #23;
    checks++;
    if (E_MDU_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", E_MDU_busy); end
    check_hilo("reset");
    reset = 1'b1;
    tick();
    check_out("reset");
  endtask

  task automatic test_mult();
    do_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, "mult_neg");
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL mult_neg const: got %h_%h expected ffffffff_fffffffa", HI, LO);
    end
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    check_out("mult");
  endtask

  task automatic test_div();
    do_op(OP_DIVU, 32'd17, 32'd5, 1'b0, "divu_17_5");
    checks++;
    if (HI !== 32'd2 || LO !== 32'd3) begin errors++; $display("FAIL divu_17_5 const: got %h_%h expected 2_3", HI, LO); end
    do_op(OP_DIV, -32'sd17, 32'd5, 1'b0, "div_m17_5");
    checks++;
    if (HI !== 32'hFFFFFFFE || LO !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_m17_5 const: got %h_%h expected fffffffe_fffffffd", HI, LO);
    end
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    checks++;
    if (HI !== 32'd0 || LO !== 32'h80000000) begin errors++; $display("FAIL div_ovf const: got %h_%h expected 0_80000000", HI, LO); end
    do_op(OP_MTHI, 32'h11, 32'd0, 1'b0, "mthi_11");
    do_op(OP_MTLO, 32'h22, 32'd0, 1'b0, "mtlo_22");
    do_op(OP_DIV, 32'd7, 32'd0, 1'b0, "div_by_zero");
    checks++;
    if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL div_by_zero const: got %h_%h expected 11_22", HI, LO); end
    do_op(OP_DIVU, 32'd7, 32'd0, 1'b0, "divu_by_zero");
  endtask

  task automatic test_mt_req();
    do_op(OP_MTLO, 32'h1234, 32'd0, 1'b1, "mtlo_req");
    do_op(OP_MULT, 32'd9, 32'd9, 1'b1, "mult_req");
    do_op(OP_MTLO, 32'h1234, 32'd0, 1'b0, "mtlo_ok");
    check_out("mtlo_ok");
    checks++;
    if (E_MDU_out !== 32'h1234) begin errors++; $display("FAIL mflo_1234: got %h expected 00001234", E_MDU_out); end
  endtask

  task automatic test_reset_mid_run();
    do_op(OP_MTHI, 32'hAAAA5555, 32'd0, 1'b0, "pre_rst_hi");
    E_MDU_op = OP_MULTU; E_A = 32'hFFFFFFFF; E_B = 32'hFFFFFFFF; E_MDU_start = 1'b1;
    tick();
    E_MDU_start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++;
    if (E_MDU_busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b expected 0", E_MDU_busy); end
    check_hilo("rst_mid");
    #2 reset = 1'b1;
    tick();
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    int n;
    int ill0;
    // req during RUN must not disturb the in-flight op.
    E_MDU_op = OP_MULT; E_A = 32'd1000; E_B = 32'hFFFFFFF9; E_MDU_start = 1'b1;
    tick();
    E_MDU_start = 1'b0;
    n = 0;
    while (E_MDU_busy && n < 40) begin n++; req = (n == 2); tick(); end
    req = 1'b0;
    checks++;
    if (n !== 5) begin errors++; $display("FAIL req_mid busy_cycles: got %0d expected 5", n); end
    model_op(OP_MULT, 32'd1000, 32'hFFFFFFF9);
    check_hilo("req_mid");
    do_op(OP_MTHI, 32'hCAFEF00D, 32'd0, 1'b0, "mthi_at_fall");
    // Start while busy is illegal: it must be ignored.
    ill0 = illegal_starts;
    E_MDU_op = OP_MULT; E_A = 32'd6; E_B = 32'd7; E_MDU_start = 1'b1;
    tick();
    E_MDU_start = 1'b0;
    n = 0;
    while (E_MDU_busy && n < 40) begin
      n++;
      E_MDU_start = (n == 3);
      E_MDU_op = (n == 3) ? OP_MTLO : OP_MULT;
      E_A = (n == 3) ? 32'hDEAD : 32'd6;
      tick();
    end
    E_MDU_start = 1'b0;
    checks++;
    if (n !== 5) begin errors++; $display("FAIL start_busy busy_cycles: got %0d expected 5", n); end
    checks++;
    if (illegal_starts - ill0 !== 1) begin
      errors++; $display("FAIL start_busy flagged: got %0d expected 1", illegal_starts - ill0);
    end
    model_op(OP_MULT, 32'd6, 32'd7);
    check_hilo("start_busy");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        rq;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      rq = ($urandom_range(0, 4) == 0);
      do_op(op, a, b, rq, $sformatf("rand%0d_op%0d", i, op));
      if (i % 5 == 0) check_out($sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_req();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencer for the multiply/divide unit in the E stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and owns the HI/LO architectural registers. It models the fixed multi-cycle operation latency and drives the busy flag that the hazard unit combines with the E-stage start signal to stall MDU-related instructions in D. It also gates new operations on the exception/interrupt request, so an instruction squashed by the CP0 flush never modifies HI/LO.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
E_MDU_op  in  4  operation code (encodings in constants.v)
E_MDU_start  in  1  E-stage instruction is a valid MDU operation this cycle
E_A  in  32  rs operand, already forwarded
E_B  in  32  rt operand, already forwarded
req  in  1  exception/interrupt flush this cycle; squashes the E-stage instruction
E_MDU_busy  out  1  multi-cycle operation in progress
E_MDU_out  out  32  HI or LO read data for mfhi/mflo
HI  out  32  architectural HI
LO  out  32  architectural LO

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, temp_hi=0, temp_lo=0, cnt=0, state=IDLE, E_MDU_busy=0.
- Accepted op: E_MDU_start & ~req & state==IDLE. Start in RUN is ignored; the hazard stall makes it illegal, and the bench asserts on it. req==1 blocks all HI/LO effects of the E-stage op.
- States: IDLE, RUN. E_MDU_busy = (state==RUN), registered, no combinational path from the inputs.
- IDLE, accepted mult/multu/div/divu:
  - On the edge, latch the result into temp_hi/temp_lo.
  - Set cnt to MULT_CYCLES or DIV_CYCLES and go to RUN.
  - Busy is high for exactly N cycles, starting the cycle after start.
- RUN: cnt decrements each edge. On the edge where cnt==1: HI<=temp_hi, LO<=temp_lo, state<=IDLE. Busy is low the following cycle and the new HI/LO are visible then.
- req asserted during RUN has no effect. The running op is older than the faulting instruction and completes.
- mult: signed 64-bit product. multu: unsigned 64-bit product. Both: HI=prod[63:32], LO=prod[31:0].
- div/divu: LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: full DIV_CYCLES busy, HI/LO unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo accepted in IDLE: HI (resp. LO) <= E_A on the edge. No busy.
- mfhi/mflo: E_MDU_out = (op==MFHI) ? HI : LO, combinational. For any other op, E_MDU_out = LO. Valid only when not busy; stalls guarantee this.
- Reset mid-RUN: the operation is abandoned and HI/LO are cleared.

Decomposition:
- constants.v holds the op encodings: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
- constants.v also holds the default cycle counts.
- Sub-module mdu_arith: purely combinational, (op, A, B) -> {res_hi, res_lo}, including the divide-by-zero and overflow rules. It keeps the sequencer free of arithmetic.

Test Plan:
1. mult A=0xFFFFFFFE (-2), B=3, start at cycle t -> busy high t+1..t+5, low at t+6; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. divu A=17, B=5 -> busy for 10 cycles, then LO=3, HI=2. div A=-17, B=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFE.
3. div A=7, B=0 with HI=0x11, LO=0x22 -> busy for 10 cycles, HI/LO remain 0x11/0x22.
4. mtlo A=0x1234 with req=1 -> LO unchanged, busy stays 0. Repeat with req=0 -> LO=0x1234 next cycle, and mflo returns 0x1234.
5. multu 0xFFFFFFFF*0xFFFFFFFF; pull reset low at cycle 3 of RUN -> busy=0, HI=LO=0 immediately. After release, the next op works normally.
6. mult followed by req=1 mid-RUN -> completes normally. mthi issued as busy falls (state back to IDLE) -> accepted. Start asserted while busy=1 -> ignored and flagged by the bench assertion.
